// File: rtl/store_buffer.sv
// Posted-write store buffer in front of a single-port data memory.
// Stores drain FIFO-order when the port is free; loads see the youngest matching pending store.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    output logic                    st_ready,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic [DATA_W-1:0]       ld_data,
    output logic                    ld_fwd,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_write_data,
    output logic                    mem_write_enable,
    input  logic [DATA_W-1:0]       mem_read_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [ADDR_W-1:0] addr_d  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  head_d;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W-1:0]  tail_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic              hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  scan_idx;
    logic              push;
    logic              drain;

    assign empty    = (count_q == '0);
    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign count    = count_q;

    // Scan oldest to youngest from head so the last match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (ld_valid && valid_q[scan_idx] && (addr_q[scan_idx] == ld_addr)) begin
                hit      = 1'b1;
                fwd_data = data_q[scan_idx];
            end
        end
    end

    assign push  = st_valid & st_ready;
    assign drain = ~empty & (~ld_valid | hit);

    assign ld_fwd           = hit;
    assign ld_data          = hit ? fwd_data : mem_read_data;
    assign mem_address      = drain ? addr_q[head_q] : ld_addr;
    assign mem_write_data   = data_q[head_q];
    assign mem_write_enable = drain;

    // Push and pop never touch the same slot: push needs !full and pop needs !empty.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q]  = st_addr;
            data_d[tail_q]  = st_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(drain);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small behavioural data memory behind it.
module tb_store_buffer;

    logic        clock;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_fwd;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;
    logic        empty;
    logic [2:0]  count;

    logic [31:0] mem [0:15];
    int unsigned writeLog[$];
    int          testsRun = 0;
    int          failCount = 0;

    store_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_fwd(ld_fwd),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
        .empty(empty), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_read_data = mem[mem_address[3:0]];

    always @(posedge clock) begin
        if (mem_write_enable) begin
            mem[mem_address[3:0]] <= mem_write_data;
            writeLog.push_back(mem_address);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic lv, input logic [31:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s differs", tag);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_st_ready", 32'(st_ready), 1);
        checkOutput("rst_we", 32'(mem_write_enable), 0);
        tick();
        reset = 1'b1;

        // Three stores held back by loads, then reset lands while the first would drain.
        applyStimulus(1, 12, 1212, 1, 0); tick();
        applyStimulus(1, 13, 1313, 1, 0); tick();
        applyStimulus(1, 14, 1414, 1, 0); tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_count3", 32'(count), 3);
        checkOutput("t1_we_pre", 32'(mem_write_enable), 1);
        checkOutput("t1_addr_pre", mem_address, 12);
        reset = 1'b0;
        #1;
        checkOutput("t1_count_rst", 32'(count), 0);
        checkOutput("t1_empty_rst", 32'(empty), 1);
        checkOutput("t1_we_rst", 32'(mem_write_enable), 0);
        tick();
        reset = 1'b1;
        tick(); tick();
        checkOutput("t1_mem12", mem[12], 0);
        checkOutput("t1_mem13", mem[13], 0);
        checkOutput("t1_mem14", mem[14], 0);
        checkOutput("t1_log", writeLog.size(), 0);

        // Single store on an empty buffer writes on the very next edge.
        applyStimulus(1, 5, 100, 0, 0);
        checkOutput("t2_we_same", 32'(mem_write_enable), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_count1", 32'(count), 1);
        checkOutput("t2_we", 32'(mem_write_enable), 1);
        checkOutput("t2_addr", mem_address, 5);
        checkOutput("t2_wdata", mem_write_data, 100);
        tick();
        checkOutput("t2_mem5", mem[5], 100);
        checkOutput("t2_empty", 32'(empty), 1);

        // Loads hog the port: fill to full, fifth store refused, then in-order drain.
        writeLog.delete();
        applyStimulus(1, 1, 11, 1, 0); tick();
        applyStimulus(1, 2, 22, 1, 0); tick();
        applyStimulus(1, 3, 33, 1, 0); tick();
        applyStimulus(1, 4, 44, 1, 0); tick();
        applyStimulus(1, 5, 55, 1, 0);
        checkOutput("t3_count4", 32'(count), 4);
        checkOutput("t3_st_ready", 32'(st_ready), 0);
        checkOutput("t3_we_blocked", 32'(mem_write_enable), 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3_count_still4", 32'(count), 4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3_first_addr", mem_address, 1);
        tick(); tick(); tick(); tick();
        checkOutput("t3_log_size", writeLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_order%0d", i), (writeLog.size() > i) ? writeLog[i] : 32'hDEAD, 32'(i + 1));
            checkOutput($sformatf("t3_mem%0d", i + 1), mem[i + 1], 32'(11 * (i + 1)));
        end
        checkOutput("t3_mem5_kept", mem[5], 100);
        checkOutput("t3_empty", 32'(empty), 1);

        // Two stores to address 7: same-cycle store not forwarded, then youngest wins.
        applyStimulus(1, 7, 10, 1, 7);
        checkOutput("t4_fwd_same", 32'(ld_fwd), 0);
        checkOutput("t4_ld_same", ld_data, 0);
        tick();
        applyStimulus(1, 7, 20, 1, 0); tick();
        applyStimulus(0, 0, 0, 1, 7);
        checkOutput("t4_ld_data", ld_data, 20);
        checkOutput("t4_ld_fwd", 32'(ld_fwd), 1);
        checkOutput("t4_drain_we", 32'(mem_write_enable), 1);
        checkOutput("t4_drain_wdata", mem_write_data, 10);
        tick();
        checkOutput("t4_ld_data2", ld_data, 20);
        checkOutput("t4_ld_fwd2", 32'(ld_fwd), 1);
        tick();
        checkOutput("t4_mem7", mem[7], 20);
        checkOutput("t4_fwd_after", 32'(ld_fwd), 0);
        checkOutput("t4_ld_mem", ld_data, 20);

        // Load miss goes to memory and holds the port.
        applyStimulus(1, 9, 32'hFFFF_FFFD, 0, 0); tick();
        applyStimulus(0, 0, 0, 0, 0); tick();
        applyStimulus(0, 0, 0, 1, 9);
        checkOutput("t5_ld_data", ld_data, 32'hFFFF_FFFD);
        checkOutput("t5_ld_fwd", 32'(ld_fwd), 0);
        checkOutput("t5_mem_addr", mem_address, 9);
        checkOutput("t5_we", 32'(mem_write_enable), 0);

        // Full buffer with pointers wrapped: push during pop is refused.
        writeLog.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'(i), 32'(1000 + i), 1, 8);
            tick();
        end
        applyStimulus(1, 15, 9999, 0, 0);
        checkOutput("t6_st_ready_full", 32'(st_ready), 0);
        checkOutput("t6_we", 32'(mem_write_enable), 1);
        checkOutput("t6_addr", mem_address, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_count3", 32'(count), 3);
        checkOutput("t6_st_ready", 32'(st_ready), 1);
        tick(); tick(); tick();
        checkOutput("t6_empty", 32'(empty), 1);
        checkOutput("t6_log_size", writeLog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t6_order%0d", i), (writeLog.size() > i) ? writeLog[i] : 32'hDEAD, 32'(i));
            checkOutput($sformatf("t6_mem%0d", i), mem[i], 32'(1000 + i));
        end
        checkOutput("t6_mem15", mem[15], 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
